// File: rtl/sram_banked_arb.sv
// ============================================================================
// sram_banked_arb
// ----------------------------------------------------------------------------
// Banked SRAM subsystem with one read/write port (port 0) and one read-only
// port (port 1). It is built from NUM_BANKS single-port 512x32 macros.
// Requests to different banks are all granted in the same cycle. Two requests
// to the same bank are serialised by a round-robin arbiter. After a conflict,
// the losing port is granted in the following cycle.
//
// Build option:
//   SRAM_BEHAV_MODEL_EN  when defined, each bank is a plain register-array
//                        model with the same timing as the macro. Use this
//                        for RTL simulation and FPGA builds. When undefined,
//                        GF180_RAM_512x32 macros are instantiated, with
//                        VDD/VSS ports under USE_POWER_PINS.
//   GF180_MACRO_LIB      define this when the foundry macro library is
//                        supplied. It removes the local stand-in model of
//                        GF180_RAM_512x32 at the bottom of this file.
//
// Ports:
//   clk        single clock for all logic and memories
//   resetn     asynchronous active-low reset
//   p0_req     port-0 request; held with its inputs until p0_gnt
//   p0_we      port-0 write enable (1 = write, 0 = read)
//   p0_wmask   port-0 byte enables for writes
//   p0_addr    port-0 word address
//   p0_wdata   port-0 write data
//   p0_gnt     port-0 accepted this cycle (combinational)
//   p0_rvalid  port-0 read data valid, one cycle after a read grant
//   p0_rdata   port-0 read data (zero unless p0_rvalid)
//   p1_req     port-1 read request; held with p1_addr until p1_gnt
//   p1_addr    port-1 word address
//   p1_gnt     port-1 accepted this cycle (combinational)
//   p1_rvalid  port-1 read data valid, one cycle after a grant
//   p1_rdata   port-1 read data (zero unless p1_rvalid)
// ============================================================================
module sram_banked_arb #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_WMASKS      = 4,
    parameter int BANK_ADDR_WIDTH = 9,
    parameter int ADDR_WIDTH      = 11
) (
`ifdef USE_POWER_PINS
    inout  wire                     VDD,
    inout  wire                     VSS,
`endif
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    p0_req,
    input  logic                    p0_we,
    input  logic [NUM_WMASKS-1:0]   p0_wmask,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [DATA_WIDTH-1:0]   p0_wdata,
    output logic                    p0_gnt,
    output logic                    p0_rvalid,
    output logic [DATA_WIDTH-1:0]   p0_rdata,
    input  logic                    p1_req,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    output logic                    p1_gnt,
    output logic                    p1_rvalid,
    output logic [DATA_WIDTH-1:0]   p1_rdata
);

    // A single-bank build still needs a 1-bit bank index so that the
    // declarations stay legal.
    localparam int BANK_SEL_WIDTH = (ADDR_WIDTH > BANK_ADDR_WIDTH) ?
                                    (ADDR_WIDTH - BANK_ADDR_WIDTH) : 1;
    localparam int NUM_BANKS      = 1 << (ADDR_WIDTH - BANK_ADDR_WIDTH);
    localparam int BYTE_WIDTH     = DATA_WIDTH / NUM_WMASKS;

    logic [BANK_SEL_WIDTH-1:0]  p0_bank;
    logic [BANK_SEL_WIDTH-1:0]  p1_bank;
    logic [BANK_ADDR_WIDTH-1:0] p0_row;
    logic [BANK_ADDR_WIDTH-1:0] p1_row;
    logic                       conflict;
    logic                       rr_p1_last;
    logic [BANK_SEL_WIDTH-1:0]  p0_rbank;
    logic [BANK_SEL_WIDTH-1:0]  p1_rbank;

    logic [NUM_BANKS-1:0]       bank_cen;
    logic [NUM_BANKS-1:0]       bank_gwen;
    logic [NUM_WMASKS-1:0]      bank_wen [NUM_BANKS];
    logic [BANK_ADDR_WIDTH-1:0] bank_a   [NUM_BANKS];
    logic [DATA_WIDTH-1:0]      bank_q   [NUM_BANKS];

    // ------------------------------------------------------------------
    // Address decode: the upper bits select a bank and the lower bits
    // select a row inside it.
    // ------------------------------------------------------------------
    assign p0_row = p0_addr[BANK_ADDR_WIDTH-1:0];
    assign p1_row = p1_addr[BANK_ADDR_WIDTH-1:0];

    if (ADDR_WIDTH > BANK_ADDR_WIDTH) begin : g_multi_bank
        assign p0_bank = p0_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
        assign p1_bank = p1_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
    end else begin : g_single_bank
        assign p0_bank = '0;
        assign p1_bank = '0;
    end

    // ------------------------------------------------------------------
    // Arbitration. Only a same-bank collision needs a decision. The port
    // that did not win the previous collision wins this one, so the loser
    // of one collision always wins the next cycle.
    // ------------------------------------------------------------------
    assign conflict = p0_req & p1_req & (p0_bank == p1_bank);
    assign p0_gnt   = resetn & p0_req & (~conflict | rr_p1_last);
    assign p1_gnt   = resetn & p1_req & (~conflict | ~rr_p1_last);

    // ------------------------------------------------------------------
    // Per-bank macro controls. At most one port owns a given bank in any
    // cycle. Port 0 is applied last only to keep the code compact: the two
    // grants never target the same bank.
    // ------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_cen[b]  = 1'b0;
            bank_gwen[b] = 1'b1;
            bank_wen[b]  = '1;
            bank_a[b]    = '0;
            if (p1_gnt && (p1_bank == BANK_SEL_WIDTH'(b))) begin
                bank_cen[b] = 1'b1;
                bank_a[b]   = p1_row;
            end
            if (p0_gnt && (p0_bank == BANK_SEL_WIDTH'(b))) begin
                bank_cen[b]  = 1'b1;
                bank_a[b]    = p0_row;
                bank_gwen[b] = ~p0_we;
                bank_wen[b]  = p0_we ? ~p0_wmask : {NUM_WMASKS{1'b1}};
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter history and read-return tracking. Each port remembers which
    // bank it read from, because the macro Q output carries the data one
    // cycle after the grant. Reset discards in-flight reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_p1_last <= 1'b1;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_rbank   <= '0;
            p1_rbank   <= '0;
        end else begin
            if (conflict) begin
                rr_p1_last <= p1_gnt;
            end
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt;
            if (p0_gnt && !p0_we) begin
                p0_rbank <= p0_bank;
            end
            if (p1_gnt) begin
                p1_rbank <= p1_bank;
            end
        end
    end

    // The bank's Q holds its last read result, so data only needs
    // selecting. It is forced to zero when no read is being returned.
    assign p0_rdata = p0_rvalid ? bank_q[p0_rbank] : '0;
    assign p1_rdata = p1_rvalid ? bank_q[p1_rbank] : '0;

    // ------------------------------------------------------------------
    // Storage banks.
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
`ifdef SRAM_BEHAV_MODEL_EN
        logic [DATA_WIDTH-1:0] mem [0:(1<<BANK_ADDR_WIDTH)-1];
        logic [DATA_WIDTH-1:0] q_reg;

        // Same contract as the macro: a byte-masked write, or a one-cycle
        // read. Q holds its value through writes and idle cycles.
        always_ff @(posedge clk) begin
            if (bank_cen[b]) begin
                if (!bank_gwen[b]) begin
                    for (int i = 0; i < NUM_WMASKS; i++) begin
                        if (!bank_wen[b][i]) begin
                            mem[bank_a[b]][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                                p0_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                        end
                    end
                end else begin
                    q_reg <= mem[bank_a[b]];
                end
            end
        end

        assign bank_q[b] = q_reg;
`else
        logic [DATA_WIDTH-1:0] q_macro;

        GF180_RAM_512x32 u_macro (
`ifdef USE_POWER_PINS
            .VDD  (VDD),
            .VSS  (VSS),
`endif
            .CLK  (clk),
            .CEN  (bank_cen[b]),
            .GWEN (bank_gwen[b]),
            .WEN  (bank_wen[b]),
            .A    (bank_a[b]),
            .D    (p0_wdata),
            .Q    (q_macro)
        );

        assign bank_q[b] = q_macro;
`endif
    end

endmodule

`ifndef SRAM_BEHAV_MODEL_EN
`ifndef GF180_MACRO_LIB
// ============================================================================
// GF180_RAM_512x32 (stand-in)
// ----------------------------------------------------------------------------
// Functional model of the 512x32 hard macro, used when the foundry library is
// not supplied. All controls are sampled on CLK.
//   CEN   1 = access this cycle
//   GWEN  0 = write, 1 = read
//   WEN   per-byte write enable, active low
//   A     row address, D write data, Q read data (held until the next read)
// ============================================================================
module GF180_RAM_512x32 (
`ifdef USE_POWER_PINS
    inout  wire         VDD,
    inout  wire         VSS,
`endif
    input  logic        CLK,
    input  logic        CEN,
    input  logic        GWEN,
    input  logic [3:0]  WEN,
    input  logic [8:0]  A,
    input  logic [31:0] D,
    output logic [31:0] Q
);

    logic [31:0] mem [0:511];

    // A write updates only the enabled bytes. A read refreshes Q. Q is
    // left unchanged otherwise.
    always_ff @(posedge CLK) begin
        if (CEN) begin
            if (!GWEN) begin
                for (int i = 0; i < 4; i++) begin
                    if (!WEN[i]) begin
                        mem[A][i*8 +: 8] <= D[i*8 +: 8];
                    end
                end
            end else begin
                Q <= mem[A];
            end
        end
    end

endmodule
`endif
`endif
